// File: rtl/multi_fan_pwm_ctrl_pkg.sv
// ============================================================================
// Module : multi_fan_pwm_ctrl_pkg
// Brief  : Shared defaults, ramp direction type and sizing helper for the fan PWM controller
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multi_fan_pwm_ctrl_pkg;

    localparam int DEF_CHANNELS     = 4;
    localparam int DEF_WIDTH        = 8;
    localparam int DEF_STEP         = 16;
    localparam int DEF_RAMP_PERIODS = 4;

    typedef enum logic [1:0] {
        RAMP_HOLD = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_dir_e;

    // Prescaler register width; a single-period ramp still needs a 1-bit register.
    function automatic int presc_width(input int ramp_periods);
        return (ramp_periods > 1) ? $clog2(ramp_periods) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_fan_pwm_ctrl_if.sv
// ============================================================================
// Module : multi_fan_pwm_ctrl_if
// Brief  : Control/status bundle between mode decode, the fan PWM controller and fan drivers
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multi_fan_pwm_ctrl_if
    import multi_fan_pwm_ctrl_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH
);

    logic [CHANNELS-1:0]       en;
    logic                      load;
    logic [CHANNELS*WIDTH-1:0] speed;
    logic [CHANNELS-1:0]       pwm_data;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS-1:0]       at_target;
    logic                      period_start;

    modport master (
        output en, load, speed,
        input  pwm_data, duty, at_target, period_start
    );

    modport slave (
        input  en, load, speed,
        output pwm_data, duty, at_target, period_start
    );

endinterface

`default_nettype wire

// File: rtl/multi_fan_pwm_ctrl_channel.sv
// ============================================================================
// Module : multi_fan_pwm_ctrl_channel
// Brief  : One fan channel (fan_pwm_channel): latched target, soft-start duty ramp, PWM compare
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_fan_pwm_ctrl_channel
    import multi_fan_pwm_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP
) (
    input  wire logic             clk,
    input  wire logic             arst,
    input  wire logic             en,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] speed,
    input  wire logic [WIDTH-1:0] cnt,
    input  wire logic             ramp_tick,
    output logic                  pwm_data,
    output logic      [WIDTH-1:0] duty,
    output logic                  at_target
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             at_target_q, at_target_d;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   step_amt;
    ramp_dir_e        dir;

    always_comb begin
        target_d    = load ? speed : target_q;
        dir         = RAMP_HOLD;
        diff        = '0;
        if (target_q > duty_q) begin
            dir  = RAMP_UP;
            diff = {1'b0, target_q} - {1'b0, duty_q};
        end else if (target_q < duty_q) begin
            dir  = RAMP_DOWN;
            diff = {1'b0, duty_q} - {1'b0, target_q};
        end
        step_amt = (diff > STEP_W) ? STEP_W : diff;

        // The ramp always steps toward the target held before this edge's load.
        duty_d = duty_q;
        if (!en) begin
            duty_d = '0;
        end else if (ramp_tick) begin
            unique case (dir)
                RAMP_UP:   duty_d = WIDTH'({1'b0, duty_q} + step_amt);
                RAMP_DOWN: duty_d = WIDTH'({1'b0, duty_q} - step_amt);
                default:   duty_d = duty_q;
            endcase
        end

        pwm_d       = en && (cnt < duty_q);
        at_target_d = en && (duty_d == target_d);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            target_q    <= '0;
            duty_q      <= '0;
            pwm_q       <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            target_q    <= target_d;
            duty_q      <= duty_d;
            pwm_q       <= pwm_d;
            at_target_q <= at_target_d;
        end
    end

    assign pwm_data  = pwm_q;
    assign duty      = duty_q;
    assign at_target = at_target_q;

endmodule

`default_nettype wire

// File: rtl/multi_fan_pwm_ctrl.sv
// ============================================================================
// Module : multi_fan_pwm_ctrl
// Brief  : CHANNELS soft-start fan PWM outputs sharing one free-running period counter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_fan_pwm_ctrl
    import multi_fan_pwm_ctrl_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int STEP         = DEF_STEP,
    parameter int RAMP_PERIODS = DEF_RAMP_PERIODS
) (
    input  wire logic           clk,
    input  wire logic           arst,
    multi_fan_pwm_ctrl_if.slave bus
);

    localparam int               PW         = presc_width(RAMP_PERIODS);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(RAMP_PERIODS - 1);
    localparam logic [WIDTH-1:0] CNT_LAST   = '1;

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [PW-1:0]             presc_q, presc_d;
    logic                      boundary;
    logic                      ramp_tick;
    logic [CHANNELS-1:0]       pwm_vec;
    logic [CHANNELS-1:0]       at_vec;
    logic [CHANNELS*WIDTH-1:0] duty_vec;

    always_comb begin
        cnt_d     = cnt_q + WIDTH'(1);
        boundary  = (cnt_q == CNT_LAST);
        ramp_tick = boundary && (presc_q == PRESC_LAST);
        presc_d   = presc_q;
        if (boundary) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt_q   <= '0;
            presc_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
        end
    end

    // Gated by arst so the marker stays low for the whole reset interval.
    assign bus.period_start = arst && (cnt_q == '0);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            multi_fan_pwm_ctrl_channel #(
                .WIDTH (WIDTH),
                .STEP  (STEP)
            ) u_fan_pwm_channel (
                .clk       (clk),
                .arst      (arst),
                .en        (bus.en[i]),
                .load      (bus.load),
                .speed     (bus.speed[i*WIDTH +: WIDTH]),
                .cnt       (cnt_q),
                .ramp_tick (ramp_tick),
                .pwm_data  (pwm_vec[i]),
                .duty      (duty_vec[i*WIDTH +: WIDTH]),
                .at_target (at_vec[i])
            );
        end
    endgenerate

    assign bus.pwm_data  = pwm_vec;
    assign bus.duty      = duty_vec;
    assign bus.at_target = at_vec;

endmodule

`default_nettype wire

// File: tb/tb_multi_fan_pwm_ctrl.sv
// ============================================================================
// Module : tb_multi_fan_pwm_ctrl
// Brief  : Randomised bench for multi_fan_pwm_ctrl against a cycle-count reference model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_fan_pwm_ctrl;

    localparam int CH   = 2;
    localparam int W    = 8;
    localparam int STEP = 16;
    localparam int RP   = 1;
    localparam int PER  = 1 << W;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    multi_fan_pwm_ctrl_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    multi_fan_pwm_ctrl #(
        .CHANNELS     (CH),
        .WIDTH        (W),
        .STEP         (STEP),
        .RAMP_PERIODS (RP)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: state derived from cycles elapsed since reset release.
    int m_n;
    int m_duty [CH];
    int m_tgt  [CH];
    bit m_pwm  [CH];
    bit m_at   [CH];

    function automatic bit is_tick(input int n);
        return ((n % PER) == PER - 1) && (((n / PER) % RP) == RP - 1);
    endfunction

    function automatic int ramp(input int d, input int t);
        if (t > d) return (t - d > STEP) ? d + STEP : t;
        if (t < d) return (d - t > STEP) ? d - STEP : t;
        return d;
    endfunction

    function automatic int next_duty(input int i);
        if (!bus.en[i]) return 0;
        if (is_tick(m_n)) return ramp(m_duty[i], m_tgt[i]);
        return m_duty[i];
    endfunction

    function automatic int next_tgt(input int i);
        return bus.load ? int'(bus.speed[i*W +: W]) : m_tgt[i];
    endfunction

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            m_n <= 0;
            for (int i = 0; i < CH; i++) begin
                m_duty[i] <= 0;
                m_tgt[i]  <= 0;
                m_pwm[i]  <= 1'b0;
                m_at[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                m_pwm[i]  <= bus.en[i] && ((m_n % PER) < m_duty[i]);
                m_at[i]   <= bus.en[i] && (next_duty(i) == next_tgt(i));
                m_duty[i] <= next_duty(i);
                m_tgt[i]  <= next_tgt(i);
            end
            m_n <= m_n + 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            check_eq($sformatf("duty%0d", i), 32'(bus.duty[i*W +: W]), 32'(m_duty[i]));
            check_eq($sformatf("pwm%0d", i), 32'(bus.pwm_data[i]), 32'(m_pwm[i]));
            check_eq($sformatf("at_target%0d", i), 32'(bus.at_target[i]), 32'(m_at[i]));
        end
        check_eq("period_start", 32'(bus.period_start), 32'(arst && ((m_n % PER) == 0)));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    // Returns at the negedge of the next cnt==0 cycle, i.e. just after a boundary.
    task automatic wait_period();
        do @(negedge clk); while ((m_n % PER) != 0);
    endtask

    task automatic load_speeds(input logic [CH*W-1:0] s);
        step();
        bus.speed = s;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
    endtask

    task automatic count_high(input int ch, output int highs);
        highs = 0;
        repeat (PER) begin
            @(negedge clk);
            if (bus.pwm_data[ch]) highs++;
        end
    endtask

    int highs;

    initial begin
        bus.en    = '0;
        bus.load  = 1'b0;
        bus.speed = '0;
        repeat (3) @(posedge clk);
        #2 arst = 1'b1;
        #1 check_eq("ps_after_release", 32'(bus.period_start), 32'd1);

        // Soft-start to 64 on ch0 only
        bus.en = 2'b01;
        load_speeds({8'd0, 8'd64});
        for (int k = 1; k <= 4; k++) begin
            wait_period();
            check_eq("t1_ramp", 32'(bus.duty[W-1:0]), 32'(16 * k));
        end
        check_eq("t1_at_target", 32'(bus.at_target[0]), 32'd1);
        count_high(0, highs);
        check_eq("t1_high_count", 32'(highs), 32'd64);
        check_eq("t1_ch1_duty", 32'(bus.duty[2*W-1:W]), 32'd0);

        // Ramp down without undershoot
        load_speeds({8'd0, 8'd8});
        for (int k = 0; k < 5; k++) begin
            wait_period();
            check_eq("t2_ramp_down", 32'(bus.duty[W-1:0]), 32'((k < 3) ? 48 - 16 * k : 8));
        end

        // Drop enable mid-period, then soft-start toward the retained target
        load_speeds({8'd0, 8'd100});
        wait_cycles(int'($urandom_range(20, 200)));
        bus.en = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check_eq("t3_duty_off", 32'(bus.duty[W-1:0]), 32'd0);
        check_eq("t3_pwm_off", 32'(bus.pwm_data[0]), 32'd0);
        wait_cycles(int'($urandom_range(5, 300)));
        bus.en = 2'b01;
        wait_period();
        check_eq("t3_restart1", 32'(bus.duty[W-1:0]), 32'd16);
        wait_period();
        check_eq("t3_restart2", 32'(bus.duty[W-1:0]), 32'd32);

        // Load coinciding with a ramp tick
        step();
        bus.en = 2'b00;
        step();
        bus.en = 2'b01;
        load_speeds({8'd0, 8'd32});
        wait_period();
        check_eq("t4_pre", 32'(bus.duty[W-1:0]), 32'd16);
        do step(); while ((m_n % PER) != PER - 1);
        bus.speed = {8'd0, 8'd128};
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        wait_period();
        check_eq("t4_old_target", 32'(bus.duty[W-1:0]), 32'd32);
        wait_period();
        check_eq("t4_new_target", 32'(bus.duty[W-1:0]), 32'd48);

        // Full-scale and zero duty
        bus.en = 2'b11;
        load_speeds({8'd255, 8'd0});
        repeat (18) wait_period();
        check_eq("t5_duty255", 32'(bus.duty[2*W-1:W]), 32'd255);
        count_high(1, highs);
        check_eq("t5_high255", 32'(highs), 32'd255);
        count_high(0, highs);
        check_eq("t5_high0", 32'(highs), 32'd0);

        // Random loads, enables and boundary-aligned loads
        for (int it = 0; it < 25; it++) begin
            wait_cycles(int'($urandom_range(1, 700)));
            case ($urandom_range(0, 3))
                0: load_speeds((CH*W)'($urandom));
                1: bus.en = CH'($urandom);
                2: begin
                    do step(); while ((m_n % PER) != PER - 1);
                    bus.speed = (CH*W)'($urandom);
                    bus.load  = 1'b1;
                    step();
                    bus.load  = 1'b0;
                end
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of a ramp
        bus.en = 2'b11;
        load_speeds({8'd200, 8'd180});
        wait_cycles(600);
        @(posedge clk);
        #3 arst = 1'b0;
        #1;
        check_eq("t6_duty_rst", 32'(bus.duty), 32'd0);
        check_eq("t6_pwm_rst", 32'(bus.pwm_data), 32'd0);
        check_eq("t6_at_rst", 32'(bus.at_target), 32'd0);
        check_eq("t6_ps_rst", 32'(bus.period_start), 32'd0);
        repeat (3) @(posedge clk);
        #2 arst = 1'b1;
        #1 check_eq("t6_ps_release", 32'(bus.period_start), 32'd1);
        load_speeds({8'd200, 8'd180});
        wait_period();
        check_eq("t6_restart0", 32'(bus.duty[W-1:0]), 32'd16);
        check_eq("t6_restart1", 32'(bus.duty[2*W-1:W]), 32'd16);
        wait_cycles(2 * PER);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
